// File: rtl/insecure_block_store.sv
// Plain, non-oblivious block store that answers the ORAM frontend command/data protocol.
// Latency: command accept -> AccessLatency+1 WAIT cycles -> data phase, with first read beat right after WAIT.
// Backpressure: CmdReady only when idle, DataInValid may stall freely, DataOut holds until DataOutReady.
module insecure_block_store #(
  parameter int ORAMU         = 32,
  parameter int ORAMB         = 512,
  parameter int FEDWidth      = 32,
  parameter int NumBlocks     = 64,
  parameter int AccessLatency = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [1:0]          Cmd,
  input  logic [ORAMU-1:0]    PAddr,
  input  logic                CmdValid,
  output logic                CmdReady,
  input  logic [FEDWidth-1:0] DataIn,
  input  logic                DataInValid,
  output logic                DataInReady,
  output logic [FEDWidth-1:0] DataOut,
  output logic                DataOutValid,
  input  logic                DataOutReady,
  output logic                ErrAppendExists,
  output logic                ErrNotFound
);

  localparam int Chunks = ORAMB / FEDWidth;
  localparam int BIdxW  = $clog2(NumBlocks);
  localparam int CW     = $clog2(Chunks);
  localparam int LatW   = (AccessLatency > 0) ? $clog2(AccessLatency + 1) : 1;

  localparam logic [1:0] CMD_APPEND  = 2'd1;
  localparam logic [1:0] CMD_READRMV = 2'd3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_WRDATA = 2'd2;
  localparam logic [1:0] ST_RDDATA = 2'd3;

  logic [FEDWidth-1:0] mem_q [NumBlocks*Chunks];

  logic [1:0]          state_q, state_d;
  logic [1:0]          cmd_q, cmd_d;
  logic [BIdxW-1:0]    idx_q, idx_d;
  logic [LatW-1:0]     lat_q, lat_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NumBlocks-1:0] blk_vld_q, blk_vld_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                din_rdy_q, din_rdy_d;
  logic [FEDWidth-1:0] dout_q, dout_d;
  logic                dout_vld_q, dout_vld_d;
  logic                err_ae_q, err_ae_d;
  logic                err_nf_q, err_nf_d;

  logic                mem_we;
  logic [BIdxW+CW-1:0] mem_waddr;
  logic [CW-1:0]       rd_chunk;
  logic [FEDWidth-1:0] rd_data;
  logic                cmd_acc;
  logic                cur_vld;
  logic                unused_paddr_hi;

  // Upper address bits alias onto the same block.
  assign unused_paddr_hi = ^PAddr[ORAMU-1:BIdxW];

  // Next chunk to present: chunk 0 as WAIT ends, otherwise the one after the current beat.
  // Invalid blocks read back as zeros.
  always_comb begin
    rd_chunk = (state_q == ST_WAIT) ? '0 : cnt_q + CW'(1);
    rd_data  = blk_vld_q[idx_q] ? mem_q[{idx_q, rd_chunk}] : '0;
  end

  // FSM, chunk/latency counters, valid bits and sticky error flags.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    idx_d      = idx_q;
    lat_d      = lat_q;
    cnt_d      = cnt_q;
    blk_vld_d  = blk_vld_q;
    dout_d     = dout_q;
    dout_vld_d = dout_vld_q;
    err_ae_d   = err_ae_q;
    err_nf_d   = err_nf_q;
    mem_we     = 1'b0;
    mem_waddr  = {idx_q, cnt_q};
    cmd_acc    = CmdValid && cmd_ready_q;
    cur_vld    = blk_vld_q[PAddr[BIdxW-1:0]];

    case (state_q)
      ST_IDLE: begin
        if (cmd_acc) begin
          cmd_d   = Cmd;
          idx_d   = PAddr[BIdxW-1:0];
          lat_d   = LatW'(AccessLatency);
          cnt_d   = '0;
          state_d = ST_WAIT;
          if (Cmd == CMD_APPEND && cur_vld)  err_ae_d = 1'b1;
          if (Cmd != CMD_APPEND && !cur_vld) err_nf_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (lat_q == '0) begin
          cnt_d = '0;
          if (!cmd_q[1]) begin
            state_d = ST_WRDATA;
          end else begin
            // Preload chunk 0 so the first beat appears right after WAIT.
            state_d    = ST_RDDATA;
            dout_d     = rd_data;
            dout_vld_d = 1'b1;
          end
        end else begin
          lat_d = lat_q - LatW'(1);
        end
      end
      ST_WRDATA: begin
        if (DataInValid && din_rdy_q) begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(Chunks - 1)) begin
            blk_vld_d[idx_q] = 1'b1;
            state_d          = ST_IDLE;
          end
        end
      end
      default: begin
        if (dout_vld_q && DataOutReady) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(Chunks - 1)) begin
            dout_vld_d = 1'b0;
            state_d    = ST_IDLE;
            if (cmd_q == CMD_READRMV) blk_vld_d[idx_q] = 1'b0;
          end else begin
            dout_d = rd_data;
          end
        end
      end
    endcase

    // Ready is registered, so the cycle the FSM lands in IDLE never accepts.
    cmd_ready_d = (state_q == ST_IDLE) && (state_d == ST_IDLE);
    din_rdy_d   = (state_d == ST_WRDATA);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      idx_q       <= '0;
      lat_q       <= '0;
      cnt_q       <= '0;
      blk_vld_q   <= '0;
      cmd_ready_q <= 1'b0;
      din_rdy_q   <= 1'b0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      err_ae_q    <= 1'b0;
      err_nf_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      idx_q       <= idx_d;
      lat_q       <= lat_d;
      cnt_q       <= cnt_d;
      blk_vld_q   <= blk_vld_d;
      cmd_ready_q <= cmd_ready_d;
      din_rdy_q   <= din_rdy_d;
      dout_q      <= dout_d;
      dout_vld_q  <= dout_vld_d;
      err_ae_q    <= err_ae_d;
      err_nf_q    <= err_nf_d;
    end
  end

  // Block data storage; contents survive reset, validity does not.
  always_ff @(posedge Clock) begin
    if (Reset && mem_we) mem_q[mem_waddr] <= DataIn;
  end

  assign CmdReady        = cmd_ready_q;
  assign DataInReady     = din_rdy_q;
  assign DataOut         = dout_q;
  assign DataOutValid    = dout_vld_q;
  assign ErrAppendExists = err_ae_q;
  assign ErrNotFound     = err_nf_q;

endmodule

// File: tb/tb_insecure_block_store.sv
// Directed bench for insecure_block_store at default parameters.
// Table of commands with hand-computed data/error expectations plus reset corner sequences.
// Write stalls are random, read backpressure toggles every cycle on "slow" rows.
module tb_insecure_block_store;

  localparam logic [1:0] C_UPD = 2'd0;
  localparam logic [1:0] C_APP = 2'd1;
  localparam logic [1:0] C_RD  = 2'd2;
  localparam logic [1:0] C_RRM = 2'd3;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [1:0]  Cmd = '0;
  logic [31:0] PAddr = '0;
  logic        CmdValid = 1'b0;
  logic        CmdReady;
  logic [31:0] DataIn = '0;
  logic        DataInValid = 1'b0;
  logic        DataInReady;
  logic [31:0] DataOut;
  logic        DataOutValid;
  logic        DataOutReady = 1'b0;
  logic        ErrAppendExists;
  logic        ErrNotFound;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [31:0] base;
    logic        zero;
    logic        slow;
    logic        ae;
    logic        nf;
  } vec_t;

  vec_t vecs [15];

  insecure_block_store dut (
    .Clock(Clock), .Reset(Reset), .Cmd(Cmd), .PAddr(PAddr),
    .CmdValid(CmdValid), .CmdReady(CmdReady),
    .DataIn(DataIn), .DataInValid(DataInValid), .DataInReady(DataInReady),
    .DataOut(DataOut), .DataOutValid(DataOutValid), .DataOutReady(DataOutReady),
    .ErrAppendExists(ErrAppendExists), .ErrNotFound(ErrNotFound)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s timeout", name);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b0; CmdValid = 1'b0; DataInValid = 1'b0; DataOutReady = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic send_cmd(input logic [1:0] c, input logic [31:0] a);
    int n = 0;
    @(negedge Clock);
    Cmd = c; PAddr = a; CmdValid = 1'b1;
    while (!CmdReady && n < 100) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 100) timeout("cmd_accept");
    @(negedge Clock);
    CmdValid = 1'b0;
  endtask

  task automatic write_block(input logic [31:0] base, input int nch, input logic slow);
    int k = 0;
    int cyc = 0;
    logic v;
    logic busy_bad = 1'b0;
    while (k < nch && cyc < 500) begin
      @(negedge Clock);
      cyc++;
      if (CmdReady) busy_bad = 1'b1;
      v = slow ? 1'($urandom_range(0, 1)) : 1'b1;
      DataInValid = v;
      DataIn = base + k;
      if (v && DataInReady) k++;
    end
    if (k < nch) timeout("wr_beats");
    chk("wr_busy", 32'(busy_bad), 32'd0);
    if (nch == 16) begin
      @(negedge Clock);
      DataInValid = 1'b0;
      chk("wr_ready_gap", 32'(CmdReady), 32'd0);
      @(negedge Clock);
      chk("wr_ready_back", 32'(CmdReady), 32'd1);
    end
  endtask

  task automatic read_block(input logic zero, input logic [31:0] base, input logic slow);
    int k = 0;
    int cyc = 0;
    int first = -1;
    logic prev_hold = 1'b0;
    logic [31:0] prev_dat = '0;
    logic hold_bad = 1'b0;
    logic busy_bad = 1'b0;
    while (k < 16 && cyc < 500) begin
      @(negedge Clock);
      cyc++;
      if (CmdReady) busy_bad = 1'b1;
      if (prev_hold && (!DataOutValid || DataOut !== prev_dat)) hold_bad = 1'b1;
      if (DataOutValid && first < 0) first = cyc;
      DataOutReady = slow ? cyc[0] : 1'b1;
      if (DataOutValid && DataOutReady) begin
        chk($sformatf("rd_data[%0d]", k), DataOut, zero ? 32'd0 : base + k);
        k++;
      end
      prev_hold = DataOutValid && !DataOutReady;
      prev_dat  = DataOut;
    end
    if (k < 16) timeout("rd_beats");
    chk("rd_first_lat", 32'(first >= 8 && first <= 11), 32'd1);
    chk("rd_hold", 32'(hold_bad), 32'd0);
    chk("rd_busy", 32'(busy_bad), 32'd0);
    @(negedge Clock);
    chk("rd_end_vld", 32'(DataOutValid), 32'd0);
    chk("rd_ready_gap", 32'(CmdReady), 32'd0);
    @(negedge Clock);
    chk("rd_ready_back", 32'(CmdReady), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{C_APP, 32'h05, 32'd1,      1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{C_RD,  32'h05, 32'd1,      1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{C_UPD, 32'h05, 32'd100,    1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{C_RD,  32'h05, 32'd100,    1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{C_APP, 32'h03, 32'h300,    1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{C_RRM, 32'h03, 32'h300,    1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{C_RD,  32'h03, 32'h0,      1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{C_APP, 32'h03, 32'h310,    1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{C_RD,  32'h03, 32'h310,    1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{C_APP, 32'h45, 32'h4500,   1'b0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{C_RD,  32'h05, 32'h4500,   1'b0, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{C_UPD, 32'h10, 32'h1000,   1'b0, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{C_RD,  32'h10, 32'h1000,   1'b0, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{C_RRM, 32'h45, 32'h4500,   1'b0, 1'b0, 1'b1, 1'b1};
    vecs[14] = '{C_RD,  32'h05, 32'h0,      1'b1, 1'b1, 1'b1, 1'b1};

    // Reset values and first CmdReady timing.
    repeat (2) @(negedge Clock);
    chk("rst_cmd_ready", 32'(CmdReady), 32'd0);
    chk("rst_din_ready", 32'(DataInReady), 32'd0);
    chk("rst_dout_vld", 32'(DataOutValid), 32'd0);
    chk("rst_dout", DataOut, 32'd0);
    chk("rst_err_ae", 32'(ErrAppendExists), 32'd0);
    chk("rst_err_nf", 32'(ErrNotFound), 32'd0);
    Reset = 1'b1;
    chk("rel_ready_low", 32'(CmdReady), 32'd0);
    @(negedge Clock);
    chk("rel_ready_high", 32'(CmdReady), 32'd1);

    // Read of a never-written block: zeros, sticky not-found.
    send_cmd(C_RD, 32'h07);
    read_block(1'b1, 32'h0, 1'b0);
    chk("nf_read7", 32'(ErrNotFound), 32'd1);
    send_cmd(C_APP, 32'h07);
    write_block(32'h700, 16, 1'b0);
    chk("nf_sticky", 32'(ErrNotFound), 32'd1);
    chk("ae_after_app7", 32'(ErrAppendExists), 32'd0);
    do_reset();
    @(negedge Clock);
    chk("nf_cleared", 32'(ErrNotFound), 32'd0);

    // Main table.
    for (int i = 0; i < 15; i++) begin
      send_cmd(vecs[i].cmd, vecs[i].addr);
      if (!vecs[i].cmd[1]) write_block(vecs[i].base, 16, vecs[i].slow);
      else                 read_block(vecs[i].zero, vecs[i].base, vecs[i].slow);
      chk($sformatf("v%0d_err_ae", i), 32'(ErrAppendExists), 32'(vecs[i].ae));
      chk($sformatf("v%0d_err_nf", i), 32'(ErrNotFound), 32'(vecs[i].nf));
    end

    // Reset in the middle of an Append: block must stay invalid.
    do_reset();
    send_cmd(C_APP, 32'h09);
    write_block(32'h900, 8, 1'b0);
    do_reset();
    @(negedge Clock);
    chk("mid_rst_nf", 32'(ErrNotFound), 32'd0);
    send_cmd(C_RD, 32'h09);
    read_block(1'b1, 32'h0, 1'b0);
    chk("mid_rst_read_nf", 32'(ErrNotFound), 32'd1);

    // Update to an invalid block still writes and validates it.
    do_reset();
    send_cmd(C_UPD, 32'h20);
    write_block(32'h2000, 16, 1'b0);
    chk("upd_inv_nf", 32'(ErrNotFound), 32'd1);
    chk("upd_inv_ae", 32'(ErrAppendExists), 32'd0);
    send_cmd(C_RD, 32'h20);
    read_block(1'b0, 32'h2000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
